// File: rtl/carregador_de_instrucoes.sv
`timescale 1ns/1ps
// carregador_de_instrucoes
// Program loader: receives a byte stream (16-bit word count N, low byte first,
// followed by N little-endian 32-bit words), writes each assembled word into
// instruction memory, holds the CPU stalled for the whole load and then
// pulses cpu_start so the CPU restarts from PC 0.
// All outputs are decoded from the state register and registered data only.
// ADDR_W must satisfy 2**ADDR_W == DEPTH and be smaller than 16 so that the
// word index can be compared directly against the 16-bit count.
module carregador_de_instrucoes #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              cpu_start,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    // State encoding
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] COUNT_LO = 3'd1;
    localparam logic [2:0] COUNT_HI = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] WRITE    = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] ERROR    = 3'd6;

    // Largest legal word count, widened so the comparison cannot wrap
    localparam logic [16:0] MAX_COUNT = 17'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [15:0]       count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              error_q, error_d;

    logic              handshake;
    logic              data_handshake;
    logic [15:0]       count_full;
    logic              count_bad;
    logic              last_word;

    // A byte moves only when both sides agree on the rising edge
    assign handshake      = byte_valid & byte_ready;
    assign data_handshake = handshake & (state_q == DATA);

    // Full count as it will be once the high byte is taken
    assign count_full = {byte_in, count_q[7:0]};
    assign count_bad  = (count_full == 16'd0) || ({1'b0, count_full} > MAX_COUNT);

    // Index reaches N-1 on the final word; N >= 1 is guaranteed outside ERROR
    assign last_word  = (16'(index_q) == (count_q - 16'd1));

    // Byte-lane assembly: each lane only captures on its own handshake
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_d[gi*8 +: 8] = (data_handshake && (lane_q == 2'(gi)))
                                   ? byte_in
                                   : word_q[gi*8 +: 8];
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        index_d = index_q;
        count_d = count_q;
        words_d = words_q;
        error_d = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT_LO;
                    words_d = '0;
                end
            end

            COUNT_LO: begin
                if (handshake) begin
                    count_d = {count_q[15:8], byte_in};
                    state_d = COUNT_HI;
                end
            end

            COUNT_HI: begin
                if (handshake) begin
                    count_d = count_full;
                    if (count_bad) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                        index_d = '0;
                        lane_d  = 2'd0;
                    end
                end
            end

            DATA: begin
                if (handshake) begin
                    // Lane wraps from 3 back to 0 naturally
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                words_d = words_q + 1'b1;
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = DATA;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ERROR: begin
                if (start) begin
                    state_d = COUNT_LO;
                    error_d = 1'b0;
                    words_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over start and handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            index_q <= '0;
            count_q <= 16'd0;
            word_q  <= 32'd0;
            words_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            index_q <= index_d;
            count_q <= count_d;
            word_q  <= word_d;
            words_q <= words_d;
            error_q <= error_d;
        end
    end

    // Moore output decode
    assign byte_ready   = (state_q == COUNT_LO) || (state_q == COUNT_HI) ||
                          (state_q == DATA);
    assign mem_we       = (state_q == WRITE);
    assign mem_waddr    = index_q;
    assign mem_wdata    = word_q;
    assign cpu_stall    = (state_q != IDLE);
    assign cpu_start    = (state_q == DONE);
    assign load_error   = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
`timescale 1ns/1ps
// Testbench for carregador_de_instrucoes: directed streams, expected memory
// writes and completion counts queued by the stimulus and checked by a
// separate monitor whenever the DUT writes or pulses cpu_start.
module tb_carregador_de_instrucoes;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_stall;
    logic        cpu_start;
    logic        load_error;
    logic [8:0]  words_loaded;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [8:0] exp_done[$];
    wr_t        mon_e;
    logic [8:0] mon_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    carregador_de_instrucoes #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .cpu_stall   (cpu_stall),
        .cpu_start   (cpu_start),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every cpu_start pulse is matched against the queues
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                         mem_waddr, mem_wdata);
            end else begin
                mon_e = exp_wr.pop_front();
                $display("write addr %0h data %08h", mem_waddr, mem_wdata);
                check("write_addr", 64'(mem_waddr), 64'(mon_e.addr));
                check("write_data", 64'(mem_wdata), 64'(mon_e.data));
            end
        end
        if (cpu_start) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cpu_start: got pulse, required none");
            end else begin
                mon_n = exp_done.pop_front();
                $display("cpu_start words_loaded %0d", words_loaded);
                check("done_words_loaded", 64'(words_loaded), 64'(mon_n));
                check("done_cpu_stall", 64'(cpu_stall), 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        acc        = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = byte_ready;
            tick();
        end
        byte_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: got byte_ready 0 for 200 cycles, required 1");
        end
        if (gap) begin
            byte_in = 8'hA5;
            tick();
        end
    endtask

    task automatic send_count(input logic [15:0] n, input bit gap);
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[k*8 +: 8], gap);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic wait_done(input logic [8:0] n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (cpu_start) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no cpu_start in 50 cycles, required pulse");
        end else begin
            check("words_loaded_at_done", 64'(words_loaded), 64'(n));
            tick();
            check("cpu_start_one_cycle", 64'(cpu_start), 64'd0);
            check("cpu_stall_falls", 64'(cpu_stall), 64'd0);
        end
    endtask

    task automatic nominal_load(input bit gap);
        push_wr(8'd0, 32'h2008_0005);
        push_wr(8'd1, 32'h2009_0003);
        exp_done.push_back(9'd2);
        pulse_start();
        check("count_lo_ready", 64'(byte_ready), 64'd1);
        check("count_lo_stall", 64'(cpu_stall), 64'd1);
        check("count_lo_words_cleared", 64'(words_loaded), 64'd0);
        send_count(16'd2, gap);
        send_word(32'h2008_0005, gap);
        send_word(32'h2009_0003, gap);
        wait_done(9'd2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  iv;

        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        tick();
        tick();
        check("reset_byte_ready", 64'(byte_ready), 64'd0);
        check("reset_mem_we", 64'(mem_we), 64'd0);
        check("reset_cpu_stall", 64'(cpu_stall), 64'd0);
        check("reset_cpu_start", 64'(cpu_start), 64'd0);
        check("reset_load_error", 64'(load_error), 64'd0);
        check("reset_words_loaded", 64'(words_loaded), 64'd0);
        reset = 1'b0;
        tick();

        // Nominal load, valid always high
        nominal_load(1'b0);

        // Same stream with byte_valid toggling
        nominal_load(1'b1);

        // Bad count 0
        pulse_start();
        send_count(16'd0, 1'b0);
        check("err0_load_error", 64'(load_error), 64'd1);
        check("err0_cpu_stall", 64'(cpu_stall), 64'd1);
        check("err0_byte_ready", 64'(byte_ready), 64'd0);
        check("err0_mem_we", 64'(mem_we), 64'd0);
        tick();
        tick();
        tick();
        check("err0_held", 64'(load_error), 64'd1);
        pulse_start();
        check("err_clear_by_start", 64'(load_error), 64'd0);
        check("err_start_words", 64'(words_loaded), 64'd0);
        check("err_start_ready", 64'(byte_ready), 64'd1);

        // Bad count 257
        send_count(16'd257, 1'b0);
        check("err257_load_error", 64'(load_error), 64'd1);
        check("err257_cpu_stall", 64'(cpu_stall), 64'd1);
        pulse_start();
        check("err257_clear", 64'(load_error), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("after_reset_stall", 64'(cpu_stall), 64'd0);

        // Full memory load: N = DEPTH
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            w  = {iv, 8'hC3, ~iv, iv ^ 8'h5A};
            push_wr(iv, w);
        end
        exp_done.push_back(9'd256);
        pulse_start();
        send_count(16'd256, 1'b0);
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            w  = {iv, 8'hC3, ~iv, iv ^ 8'h5A};
            send_word(w, 1'b0);
        end
        wait_done(9'd256);

        // Mid-load reset after the 2nd data byte of word 1
        push_wr(8'd0, 32'h1122_3344);
        pulse_start();
        send_count(16'd2, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_byte_ready", 64'(byte_ready), 64'd0);
        check("midrst_cpu_stall", 64'(cpu_stall), 64'd0);
        check("midrst_words_loaded", 64'(words_loaded), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        check("midrst_still_idle", 64'(cpu_stall), 64'd0);
        nominal_load(1'b0);

        // Start during DATA is ignored
        push_wr(8'd0, 32'hDEAD_BEEF);
        push_wr(8'd1, 32'h0BAD_F00D);
        exp_done.push_back(9'd2);
        pulse_start();
        send_count(16'd2, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        pulse_start();
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_word(32'h0BAD_F00D, 1'b0);
        wait_done(9'd2);

        // Reset has priority over start and a valid byte in the same cycle
        reset      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h01;
        tick();
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        check("rst_prio_stall", 64'(cpu_stall), 64'd0);
        check("rst_prio_ready", 64'(byte_ready), 64'd0);
        check("rst_prio_words", 64'(words_loaded), 64'd0);

        tick();
        tick();
        check("writes_drained", 64'(exp_wr.size()), 64'd0);
        check("done_drained", 64'(exp_done.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
